// File: rtl/regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// regfile_bypass_sb
//   Parametrised multi-read / single-write register file for decode, with an
//   optional write-to-read bypass and a per-register pending scoreboard that
//   lets decode see RAW hazards against writebacks still in flight.
//   Register 0 always reads as zero and can never be claimed.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        asynchronous active-high reset
//   i_rd_addr    packed read addresses, port i at [i*AW +: AW]
//   o_rd_data    packed read data, port i at [i*DATA_W +: DATA_W]
//   o_rd_busy    per read port: addressed register has a pending writer
//   i_wr_en      writeback strobe
//   i_wr_addr    writeback destination
//   i_wr_data    writeback value
//   i_claim_en   issue strobe, marks i_claim_addr pending
//   i_claim_addr register claimed by a newly issued producer
//   o_pend_cnt   number of registers currently pending
// ---------------------------------------------------------------------------
module regfile_bypass_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*AW-1:0]     i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_claim_en,
  input  logic [AW-1:0]            i_claim_addr,
  output logic [AW:0]              o_pend_cnt
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_pend;
  logic [AW:0]         r_pend_cnt;

  logic                w_wr_live;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [AW:0]         w_cnt_nxt;

  assign w_wr_live = i_wr_en && (i_wr_addr != '0);

  // Storage: address 0 is never written, so it stays at its reset value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Scoreboard next state: writeback clears first, then a claim sets, so a
  // claim and writeback on the same register leaves the new producer pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_live) begin
      w_pend_nxt[i_wr_addr] = 1'b0;
    end
    if (i_claim_en && (i_claim_addr != '0)) begin
      w_pend_nxt[i_claim_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[i]};
    end
  end

  // The count is registered alongside the pend bits rather than derived
  // combinationally, keeping o_pend_cnt a clean flop output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign o_pend_cnt = r_pend_cnt;

  genvar gp;
  generate
    for (gp = 0; gp < NUM_RD; gp++) begin : g_rd
      logic [AW-1:0]     w_addr;
      logic              w_wr_match;
      logic              w_fwd;
      logic [DATA_W-1:0] w_data;

      assign w_addr     = i_rd_addr[gp*AW +: AW];
      assign w_wr_match = (BYPASS != 0) && i_wr_en && (i_wr_addr == w_addr);
      // Forwarding is suppressed under reset so reads reflect the cleared
      // array immediately, even while a write strobe is still presented.
      assign w_fwd      = w_wr_match && !i_rst;

      always_comb begin
        if (w_addr == '0) begin
          w_data = '0;
        end else if (w_fwd) begin
          w_data = i_wr_data;
        end else begin
          w_data = r_mem[w_addr];
        end
      end

      assign o_rd_data[gp*DATA_W +: DATA_W] = w_data;
      // With bypass, a same-cycle writeback resolves the hazard because its
      // data is already on the read port. pend[0] is always 0.
      assign o_rd_busy[gp] = r_pend[w_addr] && !w_wr_match;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_bypass_sb.sv
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra0 = '0, ra1 = '0, ra2 = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        cl_en = 1'b0;
  logic [4:0]  ca = '0;

  logic [31:0] rd0, rd1;
  logic [95:0] rd2;
  logic [1:0]  busy0, busy1;
  logic [2:0]  busy2;
  logic [4:0]  cnt0, cnt1;
  logic [5:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // inst 0: 16x16, 2 ports, bypass on
  regfile_bypass_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .BYPASS(1)) u_b1 (
    .i_clk(clk), .i_rst(rst), .i_rd_addr({ra1[3:0], ra0[3:0]}),
    .o_rd_data(rd0), .o_rd_busy(busy0), .i_wr_en(wr_en), .i_wr_addr(wa[3:0]),
    .i_wr_data(wd[15:0]), .i_claim_en(cl_en), .i_claim_addr(ca[3:0]),
    .o_pend_cnt(cnt0));

  // inst 1: 16x16, 2 ports, bypass off
  regfile_bypass_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .BYPASS(0)) u_b0 (
    .i_clk(clk), .i_rst(rst), .i_rd_addr({ra1[3:0], ra0[3:0]}),
    .o_rd_data(rd1), .o_rd_busy(busy1), .i_wr_en(wr_en), .i_wr_addr(wa[3:0]),
    .i_wr_data(wd[15:0]), .i_claim_en(cl_en), .i_claim_addr(ca[3:0]),
    .o_pend_cnt(cnt1));

  // inst 2: 32x32, 3 ports, bypass on
  regfile_bypass_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3), .BYPASS(1)) u_w (
    .i_clk(clk), .i_rst(rst), .i_rd_addr({ra2, ra1, ra0}),
    .o_rd_data(rd2), .o_rd_busy(busy2), .i_wr_en(wr_en), .i_wr_addr(wa),
    .i_wr_data(wd), .i_claim_en(cl_en), .i_claim_addr(ca),
    .o_pend_cnt(cnt2));

  // ---------------- behavioural model ----------------
  bit [31:0] m_mem  [3][32];
  bit        m_pend [3][32];

  function automatic int nregs(int k);  return (k == 2) ? 32 : 16; endfunction
  function automatic int nports(int k); return (k == 2) ? 3 : 2;   endfunction
  function automatic bit byp(int k);    return (k != 1);           endfunction
  function automatic bit [31:0] dmask(int k);
    return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [4:0] ra_of(int p);
    case (p)
      0:       return ra0;
      1:       return ra1;
      default: return ra2;
    endcase
  endfunction

  function automatic bit [31:0] exp_rd(int k, int p);
    int a, w;
    a = int'(ra_of(p)) % nregs(k);
    w = int'(wa) % nregs(k);
    if (a == 0) return 32'h0;
    if (byp(k) && wr_en && !rst && w == a) return wd & dmask(k);
    return m_mem[k][a];
  endfunction

  function automatic bit exp_busy(int k, int p);
    int a, w;
    a = int'(ra_of(p)) % nregs(k);
    w = int'(wa) % nregs(k);
    if (a == 0) return 1'b0;
    return m_pend[k][a] && !(byp(k) && wr_en && w == a);
  endfunction

  function automatic int exp_cnt(int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[k][i]);
    return c;
  endfunction

  function automatic logic [31:0] act_rd(int k, int p);
    case (k)
      0:       return {16'h0, rd0[p*16 +: 16]};
      1:       return {16'h0, rd1[p*16 +: 16]};
      default: return rd2[p*32 +: 32];
    endcase
  endfunction

  function automatic logic act_busy(int k, int p);
    case (k)
      0:       return busy0[p];
      1:       return busy1[p];
      default: return busy2[p];
    endcase
  endfunction

  function automatic logic [31:0] act_cnt(int k);
    case (k)
      0:       return {27'h0, cnt0};
      1:       return {27'h0, cnt1};
      default: return {26'h0, cnt2};
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model state update: a claim marks pending, a writeback stores data and
  // retires the writer; the newest claim wins when both hit one register.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          for (int i = 0; i < 32; i++) begin
            m_mem[k][i]  = '0;
            m_pend[k][i] = 1'b0;
          end
        end else begin
          int w, c;
          w = int'(wa) % nregs(k);
          c = int'(ca) % nregs(k);
          if (wr_en && w != 0) begin
            m_mem[k][w]  = wd & dmask(k);
            m_pend[k][w] = 1'b0;
          end
          if (cl_en && c != 0) m_pend[k][c] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < nports(k); p++) begin
          check($sformatf("rd_data[k%0d,p%0d]", k, p), act_rd(k, p), exp_rd(k, p));
          check($sformatf("rd_busy[k%0d,p%0d]", k, p), {31'h0, act_busy(k, p)},
                {31'h0, exp_busy(k, p)});
        end
        check($sformatf("pend_cnt[k%0d]", k), act_cnt(k), 32'(exp_cnt(k)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wa = '0; wd = '0; cl_en = 1'b0; ca = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wa = a; wd = d;
  endtask

  task automatic claim(input logic [4:0] a);
    cl_en = 1'b1; ca = a;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;

    // reset sweep
    for (int i = 0; i < 16; i++) begin
      step();
      ra0 = 5'(i); ra1 = 5'(i); ra2 = 5'(i);
      #2;
      check("lit_rst_rd", {16'h0, rd0[15:0]}, 32'h0);
      check("lit_rst_busy", {30'h0, busy0}, 32'h0);
    end
    check("lit_rst_cnt", {27'h0, cnt0}, 32'h0);

    // write / read-back
    step(); ra0 = 0; ra1 = 0; ra2 = 0; wr(5, 32'hBEEF);
    step(); wr(15, 32'h1234);
    step(); wr(0, 32'hFFFF);
    step(); idle(); ra0 = 5; ra1 = 15; ra2 = 0;
    #2;
    check("lit_rb_r5",  {16'h0, rd0[15:0]},  32'hBEEF);
    check("lit_rb_r15", {16'h0, rd0[31:16]}, 32'h1234);
    check("lit_rb_w_r5", rd2[31:0], 32'hBEEF);
    check("lit_rb_w_r0", rd2[95:64], 32'h0);
    ra0 = 0; #1;
    check("lit_rb_r0", {16'h0, rd0[15:0]}, 32'h0);

    // bypass
    step(); wr(3, 32'h0001); ra0 = 0;
    step(); wr(3, 32'h00AA); ra0 = 3;
    #2;
    check("lit_byp1", {16'h0, rd0[15:0]}, 32'h00AA);
    check("lit_byp0_same", {16'h0, rd1[15:0]}, 32'h0001);
    step(); idle();
    #2;
    check("lit_byp0_next", {16'h0, rd1[15:0]}, 32'h00AA);

    // scoreboard lifecycle
    step(); claim(7); ra0 = 7;
    #2;
    check("lit_claim_same_busy", {31'h0, busy0[0]}, 32'h0);
    step(); idle();
    #2;
    check("lit_claim_busy", {31'h0, busy0[0]}, 32'h1);
    check("lit_claim_cnt", {27'h0, cnt0}, 32'h1);
    step(); wr(7, 32'h0042);
    #2;
    check("lit_wb_busy_b1", {31'h0, busy0[0]}, 32'h0);
    check("lit_wb_data_b1", {16'h0, rd0[15:0]}, 32'h0042);
    check("lit_wb_busy_b0", {31'h0, busy1[0]}, 32'h1);
    step(); idle();
    #2;
    check("lit_wb_after_busy", {31'h0, busy0[0] | busy1[0]}, 32'h0);
    check("lit_wb_after_cnt", {27'h0, cnt0}, 32'h0);

    // simultaneous claim + writeback on a pending register
    step(); claim(9); ra0 = 9;
    step(); claim(9); wr(9, 32'h0077);
    step(); idle();
    #2;
    check("lit_cw_data", {16'h0, rd0[15:0]}, 32'h0077);
    check("lit_cw_busy", {31'h0, busy0[0]}, 32'h1);
    check("lit_cw_cnt", {27'h0, cnt0}, 32'h1);

    // async reset mid-operation
    step(); claim(10); wr(2, 32'h0022);
    step(); idle(); claim(11);
    step(); idle(); wr(2, 32'h0055); ra0 = 2;
    #2;
    check("lit_ar_pre_cnt", {27'h0, cnt0}, 32'h3);
    check("lit_ar_pre_data", {16'h0, rd0[15:0]}, 32'h0055);
    rst = 1'b1;
    #1;
    check("lit_ar_cnt", {27'h0, cnt0}, 32'h0);
    check("lit_ar_data", {16'h0, rd0[15:0]}, 32'h0);
    check("lit_ar_data_w", rd2[31:0], 32'h0);
    step(); rst = 1'b0; idle();

    // randomized traffic, biased toward a small address set for hazards
    for (int n = 0; n < 4000; n++) begin
      step();
      rst = 1'b0;
      ra0   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra1   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra2   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_en = ($urandom_range(0, 2) != 0);
      wa    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd    = $urandom;
      cl_en = ($urandom_range(0, 2) != 0);
      ca    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
      end
    end

    step(); rst = 1'b0; idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the 16x16 two-read/one-write register file.
- Generalised in data width, register count and read-port count.
- Adds optional write-to-read bypass and a per-register pending scoreboard, so decode can detect RAW hazards against in-flight writebacks.
- Sits in decode: read ports feed operand latches; the write port is driven by writeback; the claim port is driven by issue.

Parameters:
DATA_W, 16, bits per register
NUM_REGS, 16, register count; power of two, >=2; register 0 hardwired to zero
NUM_RD, 2, number of read ports, 1..4
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read returns stored value
AW, log2(NUM_REGS), address width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = register addressed by port i has a pending writer
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback destination
wr_data  in  DATA_W  writeback value
claim_en  in  1  issue strobe: mark claim_addr pending
claim_addr  in  AW  register being claimed by a newly issued producer
pend_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset (async, rst=1): all registers clear to 0, all pending bits clear, pend_cnt=0. Outputs are then combinational from cleared state: rd_data=0, rd_busy=0. Reset asserted mid-operation discards any write or claim in that cycle.
- Write: on rising clk with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are dropped.
- Read: combinational, zero latency.
  - rd_addr==0 -> rd_data=0, rd_busy=0, regardless of bypass.
  - BYPASS=1, wr_en=1, wr_addr==rd_addr!=0 -> rd_data=wr_data in the same cycle.
  - Otherwise rd_data = stored reg[rd_addr].
  - All ports are independent; any ports may alias the same address.
- Scoreboard:
  - pend[r] sets on a clock edge with claim_en=1 and claim_addr==r.
  - pend[r] clears on a clock edge with wr_en=1 and wr_addr==r.
  - Claim and writeback to the same r in the same cycle: pend stays/becomes 1 (new producer wins); data is still written.
  - Claim or writeback to r=0: ignored, pend[0] always 0.
  - A claim of an already-pending register leaves it pending; there is no counting per register.
- rd_busy[i]:
  - BYPASS=1: pend[rd_addr_i] & ~(wr_en & wr_addr==rd_addr_i). The same-cycle writeback resolves the hazard because its data is forwarded.
  - BYPASS=0: pend[rd_addr_i], unmasked.
  - A same-cycle claim never affects rd_busy; it is visible from the next cycle.
- pend_cnt:
  - Registered population count of pend, updated on the same edge as pend.
  - Range 0..NUM_REGS-1.
- No X propagation: outputs are defined for every address value.

Test Plan:
- Reset then read: rst pulse, all rd_addr sweep 0..15 -> rd_data=0, rd_busy=0, pend_cnt=0.
- Write/read-back: write R5=0xBEEF, R15=0x1234, R0=0xFFFF; next cycle read ports (5,15) -> 0xBEEF, 0x1234; read R0 -> 0x0000.
- Bypass: R3 holds 0x0001; same cycle wr_en R3=0x00AA with rd_addr0=3.
  - BYPASS=1 -> rd_data0=0x00AA in that cycle.
  - BYPASS=0 -> 0x0001 that cycle, 0x00AA next cycle.
- Scoreboard lifecycle:
  - claim R7 -> next cycle rd_busy=1 for port reading 7, pend_cnt=1.
  - writeback R7=0x0042: BYPASS=1 -> rd_busy=0 that cycle with rd_data=0x0042; BYPASS=0 -> rd_busy=1 that cycle.
  - Next cycle rd_busy=0, pend_cnt=0.
- Simultaneous claim+writeback to R9 (pend[9]=1) -> R9=written value, pend[9] remains 1, pend_cnt unchanged.
- Async reset mid-operation: with pend_cnt=3 and wr_en=1 to R2, assert rst between clock edges -> pend_cnt=0 and rd_data for R2=0 immediately, without waiting for a clock edge. Parameter sweep: DATA_W=32, NUM_REGS=32, NUM_RD=3 repeats the write/read-back and scoreboard cases.
